edf_scheduler: RTL and testbench

//  Earliest-deadline-first arbiter sharing one memory port between NUMBER_OF_QUEUES request queues.

---
 rtl/edf_scheduler.sv | 110 +++++++++++
 tb/tb_edf_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/edf_scheduler.sv
// Earliest-deadline-first arbiter: one countdown deadline per queue, offers the most
// urgent eligible queue over valid/ready and reloads its deadline on each accepted grant.
module edf_scheduler #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int PRIORITY_SIZE    = 32
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0] periods,
    input  logic [NUMBER_OF_QUEUES-1:0]                   empty,
    input  logic                                          ready,
    input  logic                                          clear_miss,
    output logic                                          valid,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]           selection,
    output logic [NUMBER_OF_QUEUES-1:0]                   miss
);

    localparam int SEL_W = $clog2(NUMBER_OF_QUEUES);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t                                         state, state_nxt;
    logic [SEL_W-1:0]                               sel_nxt;
    logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0] cnt;
    logic [NUMBER_OF_QUEUES-1:0]                    eligible;
    logic                                           any_elig;
    logic [SEL_W-1:0]                               win_idx;
    logic [PRIORITY_SIZE-1:0]                       win_cnt;
    logic                                           xfer;

    assign valid = (state == OFFER);
    assign xfer  = valid & ready;

    // Strict less-than keeps the lowest index on ties.
    always_comb begin
        any_elig = 1'b0;
        win_idx  = '0;
        win_cnt  = '1;
        eligible = '0;
        for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
            eligible[i] = !empty[i] && (periods[i] != '0);
            if (eligible[i] && (!any_elig || cnt[i] < win_cnt)) begin
                any_elig = 1'b1;
                win_idx  = SEL_W'(i);
                win_cnt  = cnt[i];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        sel_nxt   = selection;
        case (state)
            IDLE: begin
                if (any_elig) begin
                    state_nxt = OFFER;
                    sel_nxt   = win_idx;
                end
            end
            OFFER: begin
                // An offer is never pre-empted; it ends only on transfer or withdrawal.
                if (ready || empty[selection]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            selection <= '0;
        end else begin
            state     <= state_nxt;
            selection <= sel_nxt;
        end
    end

    // Deadline counters: reload on grant or while empty, otherwise count down and saturate at 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '1;
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                if ((xfer && selection == SEL_W'(i)) || empty[i]) begin
                    cnt[i] <= periods[i];
                end else if (cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - PRIORITY_SIZE'(1);
                end
            end
        end
    end

    // A miss raised in the same cycle as clear_miss survives the clear.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss <= '0;
        end else begin
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                if (cnt[i] == '0 && !empty[i] && periods[i] != '0) begin
                    miss[i] <= 1'b1;
                end else if (clear_miss) begin
                    miss[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edf_scheduler.sv
// Bench for edf_scheduler: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a deadline-level reference model.
module tb_edf_scheduler;

    localparam int N  = 4;
    localparam int PS = 32;

    logic               clock = 1'b0;
    logic               reset = 1'b0;
    logic [N-1:0][PS-1:0] periods = '0;
    logic [N-1:0]       empty = '1;
    logic               ready = 1'b0;
    logic               clear_miss = 1'b0;
    logic               valid;
    logic [1:0]         selection;
    logic [N-1:0]       miss;

    edf_scheduler #(.NUMBER_OF_QUEUES(N), .PRIORITY_SIZE(PS)) dut (
        .clock      (clock),
        .reset      (reset),
        .periods    (periods),
        .empty      (empty),
        .ready      (ready),
        .clear_miss (clear_miss),
        .valid      (valid),
        .selection  (selection),
        .miss       (miss)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic         v;
        logic [1:0]   s;
        logic [N-1:0] m;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model: time left to each queue's deadline, which queue holds the offer,
    // and which queues have ever run out of time.
    logic [PS-1:0] time_left[N];
    bit            offering;
    int            offered;
    bit [N-1:0]    missed;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        foreach (time_left[i]) time_left[i] = '1;
        offering = 0;
        offered  = 0;
        missed   = '0;
    endtask

    task automatic model_cycle();
        logic [PS-1:0] nxt[N];
        bit            granted;
        int            best;
        if (!reset) begin
            model_reset();
            return;
        end
        granted = offering && ready;
        foreach (time_left[i]) begin
            if (time_left[i] == 0 && !empty[i] && periods[i] != 0)
                missed[i] = 1;
            else if (clear_miss)
                missed[i] = 0;
            if ((granted && offered == i) || empty[i])
                nxt[i] = periods[i];
            else if (time_left[i] == 0)
                nxt[i] = 0;
            else
                nxt[i] = time_left[i] - 1;
        end
        if (!offering) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (!empty[i] && periods[i] != 0 && (best < 0 || time_left[i] < time_left[best]))
                    best = i;
            if (best >= 0) begin
                offering = 1;
                offered  = best;
            end
        end else if (ready || empty[offered]) begin
            offering = 0;
        end
        foreach (time_left[i]) time_left[i] = nxt[i];
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        exp_t e;
        model_cycle();
        e.v = offering;
        e.s = 2'(offered);
        e.m = missed;
        exp_q.push_back(e);
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("sb_valid", 32'(valid), 32'(mon_e.v));
                check("sb_selection", 32'(selection), 32'(mon_e.s));
                check("sb_miss", 32'(miss), 32'(mon_e.m));
            end
        end
    end

    initial begin
        model_reset();
        periods[0] = 40; periods[1] = 30; periods[2] = 20; periods[3] = 10;
        @(negedge clock);

        // Held in reset with all queues empty.
        for (int k = 0; k < 5; k++) begin
            step();
            check("rst_valid", 32'(valid), 0);
            check("rst_sel", 32'(selection), 0);
            check("rst_miss", 32'(miss), 0);
        end
        reset = 1'b1;
        step();

        // Queues 0 and 3 arrive; queue 3 has the nearer deadline.
        empty = 4'b0110;
        step();
        check("t2_valid", 32'(valid), 1);
        check("t2_sel", 32'(selection), 3);
        ready = 1'b1;
        step();
        check("t2_bubble", 32'(valid), 0);
        ready = 1'b0;
        step();
        check("t2_valid2", 32'(valid), 1);
        check("t2_sel2", 32'(selection), 3);
        ready = 1'b1;
        step();
        empty = '1; ready = 1'b0;
        step();

        // Equal deadlines: lowest index first, then the one that has been waiting.
        for (int i = 0; i < N; i++) periods[i] = 20;
        step();
        empty = 4'b0000;
        step();
        check("t3_sel0", 32'(selection), 0);
        ready = 1'b1;
        step();
        check("t3_bubble", 32'(valid), 0);
        ready = 1'b0;
        step();
        check("t3_valid", 32'(valid), 1);
        check("t3_sel1", 32'(selection), 1);
        empty = '1;
        step();
        check("t3_withdraw", 32'(valid), 0);

        // Short deadline on queue 2 with the offer stalled.
        periods[2] = 3;
        step();
        empty = 4'b1011;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("t4_valid", 32'(valid), 1);
            check("t4_sel", 32'(selection), 2);
            check("t4_miss2", 32'(miss[2]), (k >= 4) ? 1 : 0);
        end
        clear_miss = 1'b1;
        step();
        check("t4_set_over_clear", 32'(miss[2]), 1);
        empty = '1;
        step();
        check("t4_cleared", 32'(miss[2]), 0);
        check("t4_withdraw", 32'(valid), 0);
        clear_miss = 1'b0;

        // Asynchronous reset in the middle of an offer.
        empty = 4'b1011;
        step();
        check("t6_offer", 32'(valid), 1);
        reset = 1'b0;
        #1;
        check("t6_async_valid", 32'(valid), 0);
        check("t6_async_sel", 32'(selection), 0);
        check("t6_async_miss", 32'(miss), 0);
        #3;
        step();
        reset = 1'b1;
        step();
        check("t6_reoffer", 32'(valid), 1);
        check("t6_reoffer_sel", 32'(selection), 2);
        empty = '1;
        step();

        // Disabled queue never gets offered or flagged.
        periods[1] = 0;
        step();
        empty = 4'b1101;
        for (int k = 0; k < 4; k++) begin
            step();
            check("t5_valid", 32'(valid), 0);
            check("t5_miss", 32'(miss), 0);
        end

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            empty      = 4'($urandom);
            ready      = 1'($urandom);
            clear_miss = ($urandom_range(0, 15) == 0);
            reset      = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            if ($urandom_range(0, 23) == 0)
                periods[$urandom_range(0, N-1)] =
                    ($urandom_range(0, 9) == 0) ? PS'($urandom) : PS'($urandom_range(0, 12));
            step();
        end

        repeat (2) @(posedge clock);
        #2;
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
